cache_access_arbiter: RTL

//  Shares one cacheSim access port between NUM_REQ trace/CPU requesters. Round-robin

---
 rtl/cache_access_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cache_access_arbiter.sv
//==============================================================================
// Module      : cache_access_arbiter
// Description : Round-robin arbiter with a per-owner burst quantum. It shares
//               one registered cache access port among NUM_REQ requesters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_access_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 16,
  parameter int BURST        = 2,
  parameter int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_rw,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] i_req_address,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic                            i_cache_stall,
  output logic                            o_cache_valid,
  output logic                            o_cache_rw,
  output logic [ADDRESS_SIZE-1:0]         o_cache_address,
  output logic [SRC_W-1:0]                o_cache_src,
  output logic [NUM_REQ*32-1:0]           o_grant_count
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam logic [CNT_W-1:0] c_burst_last = CNT_W'(BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SRC_W-1:0]        r_owner;
  logic [CNT_W-1:0]        r_burst_cnt;
  logic                    r_valid;
  logic                    r_rw;
  logic [ADDRESS_SIZE-1:0] r_address;
  logic [SRC_W-1:0]        r_src;
  logic [31:0]             r_gcnt [NUM_REQ];

  logic                    w_load_en;
  logic                    w_any;
  logic                    w_accept;
  logic [SRC_W-1:0]        w_sel;
  logic                    w_found;
  int                      w_idx;

  assign w_load_en = !r_valid || !i_cache_stall;
  assign w_any     = |i_req_valid;
  assign w_accept  = w_load_en && w_any;

  // Owner keeps the port while its quantum lasts; otherwise scan from owner+1,
  // visiting the owner last so a lone requester can still be served.
  always_comb begin
    w_sel   = r_owner;
    w_found = 1'b0;
    w_idx   = 0;
    if (r_state == S_BURST && i_req_valid[r_owner] && r_burst_cnt < c_burst_last) begin
      w_sel   = r_owner;
      w_found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_idx = (int'(r_owner) + k) % NUM_REQ;
        if (!w_found && i_req_valid[w_idx]) begin
          w_sel   = SRC_W'(w_idx);
          w_found = 1'b1;
        end
      end
    end
  end

  assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= SRC_W'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_valid     <= 1'b0;
      r_rw        <= 1'b0;
      r_address   <= '0;
      r_src       <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_valid   <= 1'b1;
        r_rw      <= i_req_rw[w_sel];
        r_address <= i_req_address[w_sel*ADDRESS_SIZE +: ADDRESS_SIZE];
        r_src     <= w_sel;
        if (r_gcnt[w_sel] != 32'hFFFF_FFFF) r_gcnt[w_sel] <= r_gcnt[w_sel] + 32'd1;
        if (w_sel == r_owner && r_state == S_BURST) begin
          // Saturating keeps a lone requester from wrapping back into a fresh quantum.
          if (r_burst_cnt != c_burst_last) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end else begin
          r_owner     <= w_sel;
          r_burst_cnt <= '0;
          r_state     <= S_BURST;
        end
      end else begin
        r_valid <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end

  assign o_cache_valid   = r_valid;
  assign o_cache_rw      = r_rw;
  assign o_cache_address = r_address;
  assign o_cache_src     = r_src;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign o_grant_count[g*32 +: 32] = r_gcnt[g];
    end
  endgenerate

endmodule

`default_nettype wire
